// File: rtl/miner_pkg.sv
// Shared types and constants for the miner work loader.
package miner_pkg;

  localparam int unsigned HDR_BYTES    = 80;
  localparam int unsigned MSG_BITS     = 640;
  // Bytes 76..79 are the nonce; only bytes 0..75 are kept.
  localparam int unsigned SHADOW_BYTES = HDR_BYTES - 4;
  localparam int unsigned SHADOW_BITS  = SHADOW_BYTES * 8;
  localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;

  typedef logic [511:0] block_t;
  typedef logic [255:0] hash_t;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DROP  = 2'd1,
    WAIT  = 2'd2,
    START = 2'd3
  } loader_state_t;

endpackage

// File: rtl/nbits_to_target.sv
// Combinational expansion of the compact nBits field into a 256-bit target.
//   nbits    in   32   {exponent[7:0], sign, mantissa[22:0]}
//   target   out  256  expanded target
//   overflow out  1    exponent above 32; target saturates to all-ones
module nbits_to_target
  import miner_pkg::*;
(
  input  logic [31:0] nbits,
  output hash_t       target,
  output logic        overflow
);

  logic [7:0]   expo;
  logic [255:0] mant;
  logic [4:0]   rsh;
  logic [7:0]   lsh;

  assign expo = nbits[31:24];
  assign mant = 256'(nbits[22:0]);
  // Right shift in bytes for E<=3: (3-E) bytes.
  assign rsh  = {2'd3 - expo[1:0], 3'b000};
  // Left shift in bytes for 3<E<=32: (E-3) mod 32 gives 29 for E=32 as needed.
  assign lsh  = {expo[4:0] - 5'd3, 3'b000};

  always_comb begin
    target   = '0;
    overflow = 1'b0;
    if (nbits[23] || (nbits[22:0] == 23'd0)) begin
      target = '0;
    end else if (expo <= 8'd3) begin
      target = mant >> rsh;
    end else if (expo <= 8'd32) begin
      target = mant << lsh;
    end else begin
      target   = '1;
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/miner_work_loader.sv
// Collects an 80-byte block header from a byte stream, builds the two SHA-256
// message blocks and the target, and launches the miner once it is idle.
// The shadow register fills while a job runs; outputs only change on launch.
//   clk, rst_n      clock, async active-low reset
//   in_valid/in_data/in_last/in_ready   header byte stream
//   miner_busy      miner busy flag
//   miner_start     one-cycle launch pulse (job_loaded mirrors it)
//   block0          header bytes 0..63, byte 0 in the top byte
//   block1_tmpl     bytes 64..75, zero nonce, SHA padding, length 640
//   target          expanded nBits
//   hdr_err         one-cycle pulse on a malformed header or nBits overflow
module miner_work_loader
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         miner_busy,
  output logic         miner_start,
  output logic [511:0] block0,
  output logic [511:0] block1_tmpl,
  output logic [255:0] target,
  output logic         hdr_err,
  output logic         job_loaded
);

  localparam logic [6:0] LAST_IDX   = 7'(HDR_BYTES - 1);
  localparam logic [6:0] SHADOW_END = 7'(SHADOW_BYTES);

  loader_state_t          state_q, state_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [SHADOW_BITS-1:0] hdr_q, hdr_d;
  logic                   in_ready_q, in_ready_d;
  logic                   start_q, start_d;
  logic                   job_q, job_d;
  logic                   err_q, err_d;
  block_t                 block0_q, block0_d;
  block_t                 block1_q, block1_d;
  hash_t                  target_q, target_d;

  logic        accept;
  logic [31:0] nbits_c;
  hash_t       target_c;
  logic        overflow_c;

  // Shadow is a shift register: byte 0 ends up in the top byte after 76 shifts.
  // nBits is little-endian at bytes 72..75, i.e. the low four shadow bytes.
  assign nbits_c = {hdr_q[7:0], hdr_q[15:8], hdr_q[23:16], hdr_q[31:24]};

  nbits_to_target u_nbits (
    .nbits    (nbits_c),
    .target   (target_c),
    .overflow (overflow_c)
  );

  assign accept = in_valid & in_ready_q;

  // Next-state, framing and launch logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    start_d  = 1'b0;
    job_d    = 1'b0;
    err_d    = 1'b0;
    block0_d = block0_q;
    block1_d = block1_q;
    target_d = target_q;

    case (state_q)
      RECV: begin
        if (accept) begin
          if (cnt_q < SHADOW_END) begin
            hdr_d = {hdr_q[SHADOW_BITS-9:0], in_data};
          end
          if (in_last) begin
            cnt_d = 7'd0;
            if (cnt_q == LAST_IDX) begin
              state_d = WAIT;
            end else begin
              err_d = 1'b1;
            end
          end else if (cnt_q == LAST_IDX) begin
            err_d   = 1'b1;
            cnt_d   = 7'd0;
            state_d = DROP;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          state_d = RECV;
          cnt_d   = 7'd0;
        end
      end
      WAIT: begin
        // Outputs load on the same edge the start pulse rises.
        if (!miner_busy) begin
          state_d  = START;
          start_d  = 1'b1;
          job_d    = 1'b1;
          err_d    = overflow_c;
          block0_d = hdr_q[SHADOW_BITS-1:96];
          block1_d = {hdr_q[95:0], 32'h0, SHA_PAD_BYTE, 312'h0, 64'(MSG_BITS)};
          target_d = target_c;
        end
      end
      START: begin
        state_d = RECV;
      end
    endcase

    in_ready_d = (state_d == RECV) || (state_d == DROP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RECV;
      cnt_q      <= '0;
      hdr_q      <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      job_q      <= 1'b0;
      err_q      <= 1'b0;
      block0_q   <= '0;
      block1_q   <= '0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      job_q      <= job_d;
      err_q      <= err_d;
      block0_q   <= block0_d;
      block1_q   <= block1_d;
      target_q   <= target_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign miner_start = start_q;
  assign job_loaded  = job_q;
  assign hdr_err     = err_q;
  assign block0      = block0_q;
  assign block1_tmpl = block1_q;
  assign target      = target_q;

endmodule

// File: tb/tb_miner_work_loader.sv
// Directed bench for miner_work_loader: nBits vector table plus framing,
// back-pressure and reset sequences.
module tb_miner_work_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic         miner_busy;
  logic         miner_start;
  logic [511:0] block0;
  logic [511:0] block1_tmpl;
  logic [255:0] target;
  logic         hdr_err;
  logic         job_loaded;

  always #5 clk = ~clk;

  miner_work_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .miner_busy  (miner_busy),
    .miner_start (miner_start),
    .block0      (block0),
    .block1_tmpl (block1_tmpl),
    .target      (target),
    .hdr_err     (hdr_err),
    .job_loaded  (job_loaded)
  );

  typedef struct {
    logic [31:0]  nbits;
    logic [255:0] tgt;
    logic         err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int start_pulses = 0;
  int err_pulses = 0;
  int busy_viol = 0;
  logic [7:0] hdr [80];

  always @(negedge clk) begin
    if (miner_start) begin
      start_pulses++;
      if (miner_busy) busy_viol++;
    end
    if (hdr_err) err_pulses++;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic build_hdr(input int seed, input logic [31:0] nb);
    for (int i = 0; i < 80; i++) hdr[i] = 8'(i * 3 + seed);
    hdr[72] = nb[7:0];
    hdr[73] = nb[15:8];
    hdr[74] = nb[23:16];
    hdr[75] = nb[31:24];
  endtask

  function automatic logic [511:0] exp_b0();
    logic [511:0] r = '0;
    for (int i = 0; i < 64; i++) r = {r[503:0], hdr[i]};
    return r;
  endfunction

  function automatic logic [511:0] exp_b1();
    logic [95:0] r = '0;
    for (int i = 64; i < 76; i++) r = {r[87:0], hdr[i]};
    return {r, 32'h0, 8'h80, 312'h0, 64'd640};
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_hdr();
    for (int i = 0; i < 80; i++) send_byte(hdr[i], i == 79);
  endtask

  // Waits for the start pulse and checks the latency in negedges.
  task automatic wait_start(input string name, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!miner_start && lat < 20);
    check({name, "_latency"}, 512'(lat), 512'(exp_lat));
  endtask

  // Called at the negedge of the start pulse.
  task automatic check_job(input string name, input logic [255:0] tgt, input logic err);
    check({name, "_job_loaded"}, 512'(job_loaded), 512'(1'b1));
    check({name, "_hdr_err"},    512'(hdr_err),    512'(err));
    check({name, "_block0"},     block0,           exp_b0());
    check({name, "_block1"},     block1_tmpl,      exp_b1());
    check({name, "_target"},     512'(target),     512'(tgt));
    @(negedge clk);
    check({name, "_single_pulse"}, 512'(miner_start), 512'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int s0, e0;
    logic [511:0] prev_b0;
    logic [255:0] prev_t;

    vecs[0] = '{32'h1d00ffff, {32'h0, 16'hffff, 208'h0}, 1'b0};
    vecs[1] = '{32'h03123456, 256'h123456,               1'b0};
    vecs[2] = '{32'h2100ffff, {256{1'b1}},               1'b1};
    vecs[3] = '{32'h04923456, 256'h0,                    1'b0};
    vecs[4] = '{32'h01123456, 256'h12,                   1'b0};
    vecs[5] = '{32'h20123456, {24'h123456, 232'h0},      1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0; miner_busy = 1'b0;
    #12;
    check("rst_in_ready",    512'(in_ready),    512'(1'b0));
    check("rst_miner_start", 512'(miner_start), 512'(1'b0));
    check("rst_block0",      block0,            512'h0);
    check("rst_block1",      block1_tmpl,       512'h0);
    check("rst_target",      512'(target),      512'h0);
    check("rst_hdr_err",     512'(hdr_err),     512'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 512'(in_ready), 512'(1'b1));

    // nBits table, miner idle.
    for (int v = 0; v < 6; v++) begin
      build_hdr(v * 17 + 1, vecs[v].nbits);
      send_hdr();
      wait_start($sformatf("vec%0d", v), 2);
      check_job($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].err);
    end

    // Header B streams in while the miner is busy.
    miner_busy = 1'b1;
    prev_b0 = block0;
    prev_t  = target;
    s0 = start_pulses;
    build_hdr(99, 32'h1b0404cb);
    send_hdr();
    @(negedge clk);
    check("busy_in_ready_low", 512'(in_ready), 512'(1'b0));
    repeat (5) @(negedge clk);
    check("busy_no_start",     512'(start_pulses - s0), 512'(0));
    check("busy_block0_hold",  block0,                  prev_b0);
    check("busy_target_hold",  512'(target),            512'(prev_t));
    check("busy_in_ready_hold", 512'(in_ready),         512'(1'b0));
    miner_busy = 1'b0;
    wait_start("hdr_b", 1);
    check_job("hdr_b", {40'h0, 24'h0404cb, 192'h0}, 1'b0);

    // Early in_last at byte 40.
    s0 = start_pulses; e0 = err_pulses;
    build_hdr(5, 32'h1d00ffff);
    for (int i = 0; i <= 40; i++) send_byte(hdr[i], i == 40);
    @(negedge clk);
    check("short_hdr_err", 512'(hdr_err), 512'(1'b1));
    repeat (4) @(negedge clk);
    check("short_no_start", 512'(start_pulses - s0), 512'(0));
    check("short_err_once", 512'(err_pulses - e0),   512'(1));
    build_hdr(33, 32'h1d00ffff);
    send_hdr();
    wait_start("after_short", 2);
    check_job("after_short", {32'h0, 16'hffff, 208'h0}, 1'b0);

    // 85-byte header: error at byte 79, bytes 80..84 dropped.
    s0 = start_pulses; e0 = err_pulses;
    build_hdr(71, 32'h03123456);
    for (int i = 0; i < 80; i++) send_byte(hdr[i], 1'b0);
    @(negedge clk);
    check("long_hdr_err", 512'(hdr_err), 512'(1'b1));
    for (int i = 80; i < 85; i++) send_byte(8'(i), i == 84);
    repeat (4) @(negedge clk);
    check("long_no_start", 512'(start_pulses - s0), 512'(0));
    check("long_err_once", 512'(err_pulses - e0),   512'(1));
    check("long_in_ready", 512'(in_ready),          512'(1'b1));
    build_hdr(44, 32'h03123456);
    send_hdr();
    wait_start("after_long", 2);
    check_job("after_long", 256'h123456, 1'b0);

    // Reset after 30 bytes.
    build_hdr(88, 32'h1d00ffff);
    for (int i = 0; i < 30; i++) send_byte(hdr[i], 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_block0",   block0,            512'h0);
    check("midrst_block1",   block1_tmpl,       512'h0);
    check("midrst_target",   512'(target),      512'h0);
    check("midrst_in_ready", 512'(in_ready),    512'(1'b0));
    check("midrst_start",    512'(miner_start), 512'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_pulses;
    build_hdr(123, 32'h1d00ffff);
    send_hdr();
    wait_start("after_rst", 2);
    check_job("after_rst", {32'h0, 16'hffff, 208'h0}, 1'b0);
    repeat (5) @(negedge clk);
    check("after_rst_one_start", 512'(start_pulses - s0), 512'(1));
    check("start_while_busy",    512'(busy_viol),         512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
